// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: funct3 access sizes, WB select codes, MEM FSM states
// and the data-memory request bundle.
package riscv_pkg;
  localparam int XLEN      = 32;
  localparam int NUM_LANES = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WB_SEL_MEM = 2'b00;
  localparam logic [1:0] WB_SEL_ALU = 2'b01;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic                 req;
    logic                 we;
    logic [XLEN-1:0]      addr;
    logic [NUM_LANES-1:0] be;
    logic [XLEN-1:0]      wdata;
  } dmem_req_t;
endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for the MEM stage: byte enables, store replication,
// load extraction with sign/zero extension, and misalign/illegal decode.
module load_store_align
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [1:0]           lane,
  input  logic [2:0]           funct3,
  input  logic                 is_load,
  input  logic [XLEN-1:0]      store_data,
  input  logic [XLEN-1:0]      rdata,
  output logic [NUM_LANES-1:0] be,
  output logic [XLEN-1:0]      wdata,
  output logic [XLEN-1:0]      load_data,
  output logic                 fault
);
  logic [NUM_LANES-1:0][7:0] rd_b;
  logic [7:0]                byte_v;
  logic [15:0]               half_v;
  logic                      legal, misal;

  assign rd_b = rdata;

  // Each lane carries either the low byte, the matching half of the low
  // halfword, or its own byte, so any aligned lane sees the right data.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wdata[8*i +: 8] = (funct3[1:0] == 2'b00) ? store_data[7:0] :
                             (funct3[1:0] == 2'b01) ? store_data[8*(i%2) +: 8] :
                                                      store_data[8*i +: 8];
  end

  always_comb begin
    be = '1;
    if (!is_load) begin
      unique case (funct3[1:0])
        2'b00:   be = 4'b0001 << lane;
        2'b01:   be = 4'b0011 << lane;
        default: be = 4'b1111;
      endcase
    end
  end

  always_comb begin
    byte_v    = rd_b[lane];
    half_v    = lane[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    unique case (funct3)
      F3_B:    load_data = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, byte_v};
      F3_H:    load_data = {{(XLEN-16){half_v[15]}}, half_v};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, half_v};
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    legal = is_load ? (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
                    : (funct3 inside {F3_B, F3_H, F3_W});
    misal = ((funct3[1:0] == 2'b01) && lane[0]) ||
            ((funct3[1:0] == 2'b10) && (lane != 2'b00));
    fault = !legal || misal;
  end
endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: data-memory req/ready handshake, load alignment and the
// MEM/WB pipeline register feeding WB.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] store_data,
  input  logic [2:0]      funct3,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            reg_file_write_in,
  input  logic [4:0]      addr_rd_in,
  input  logic [1:0]      select_mux_2_in,
  output logic            stall_out,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            reg_file_write_out,
  output logic [4:0]      addr_rd_out,
  output logic [1:0]      select_mux_2_out,
  output logic [XLEN-1:0] mem_out,
  output logic [XLEN-1:0] alu_out,
  output logic            fault_out
);
  mem_state_e      state_q, state_d;
  dmem_req_t       req_s;
  logic            memop, is_store, align_fault, fault, legal;
  logic [3:0]      be_w;
  logic [XLEN-1:0] wdata_w, load_w;

  assign memop    = valid_in && (mem_read || mem_write);
  assign is_store = mem_write && !mem_read;
  assign fault    = memop && align_fault;
  assign legal    = memop && !align_fault;

  load_store_align #(.XLEN(XLEN)) u_align (
    .lane       (alu_result[1:0]),
    .funct3     (funct3),
    .is_load    (mem_read),
    .store_data (store_data),
    .rdata      (dmem_rdata),
    .be         (be_w),
    .wdata      (wdata_w),
    .load_data  (load_w),
    .fault      (align_fault)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MEM_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MEM_IDLE: if (legal && !dmem_ready) state_d = MEM_WAIT;
      MEM_WAIT: if (dmem_ready)           state_d = MEM_IDLE;
      default:                            state_d = MEM_IDLE;
    endcase
  end

  // rst gates the request so an access in flight is dropped at once, even
  // though EX/MEM may still be presenting the load.
  always_comb begin
    req_s     = '0;
    req_s.req = !rst && (legal || (state_q == MEM_WAIT));
    if (req_s.req) begin
      req_s.we    = is_store;
      req_s.addr  = {alu_result[XLEN-1:2], 2'b00};
      req_s.be    = be_w;
      req_s.wdata = wdata_w;
    end
    stall_out = req_s.req && !dmem_ready;
  end

  assign dmem_req   = req_s.req;
  assign dmem_we    = req_s.we;
  assign dmem_addr  = req_s.addr;
  assign dmem_be    = req_s.be;
  assign dmem_wdata = req_s.wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_file_write_out <= 1'b0;
      addr_rd_out        <= '0;
      select_mux_2_out   <= '0;
      mem_out            <= '0;
      alu_out            <= '0;
      fault_out          <= 1'b0;
    end else if (!stall_out) begin
      reg_file_write_out <= valid_in && reg_file_write_in && !is_store && !fault;
      addr_rd_out        <= addr_rd_in;
      select_mux_2_out   <= select_mux_2_in;
      mem_out            <= (valid_in && mem_read && !fault) ? load_w : '0;
      alu_out            <= alu_result;
      fault_out          <= fault;
    end else begin
      fault_out          <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a spec-level model sets expectations per
// cycle, a negedge process compares, and literal pins anchor the model.
module tb_mem_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        valid_in = 0, mem_read = 0, mem_write = 0, reg_file_write_in = 0;
  logic [31:0] alu_result = 0, store_data = 0, dmem_rdata = 0;
  logic [2:0]  funct3 = 0;
  logic [4:0]  addr_rd_in = 0;
  logic [1:0]  select_mux_2_in = 0;
  logic        dmem_ready = 0;
  logic        stall_out, dmem_req, dmem_we, reg_file_write_out, fault_out;
  logic [31:0] dmem_addr, dmem_wdata, mem_out, alu_out;
  logic [3:0]  dmem_be;
  logic [4:0]  addr_rd_out;
  logic [1:0]  select_mux_2_out;

  mem_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_result(alu_result),
    .store_data(store_data), .funct3(funct3), .mem_read(mem_read),
    .mem_write(mem_write), .reg_file_write_in(reg_file_write_in),
    .addr_rd_in(addr_rd_in), .select_mux_2_in(select_mux_2_in),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .reg_file_write_out(reg_file_write_out), .addr_rd_out(addr_rd_out),
    .select_mux_2_out(select_mux_2_out), .mem_out(mem_out),
    .alu_out(alu_out), .fault_out(fault_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  bit chk_en = 0;

  // expected outputs
  bit          e_req, e_stall, e_we, e_rfw, e_fault;
  logic [31:0] e_addr, e_wdata, e_mem, e_alu;
  logic [3:0]  e_be;
  logic [4:0]  e_rd;
  logic [1:0]  e_sel;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- model: the access rules written as plain arithmetic ----
  function automatic bit m_fault(input bit mr, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    int unsigned bytes;
    if (mr) legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    else    legal = (f3 == 0) || (f3 == 1) || (f3 == 2);
    bytes = 1 << f3[1:0];
    return !legal || ((a % bytes) != 0);
  endfunction

  function automatic logic [3:0] m_be(input bit mr, input logic [2:0] f3, input logic [31:0] a);
    int unsigned lane = a % 4;
    if (mr) return 4'hF;
    if (f3[1:0] == 0) return 4'(1 << lane);
    if (f3[1:0] == 1) return 4'(3 << lane);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    if (f3[1:0] == 0) return (sd & 32'hFF) * 32'h0101_0101;
    if (f3[1:0] == 1) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] sh = rd >> (8 * (a % 4));
    logic [31:0] v;
    case (f3)
      3'd0: begin v = sh & 32'hFF;   if (v >= 128)   v = v - 32'd256;   end
      3'd4: v = sh & 32'hFF;
      3'd1: begin v = sh & 32'hFFFF; if (v >= 32768) v = v - 32'd65536; end
      3'd5: v = sh & 32'hFFFF;
      default: v = rd;
    endcase
    return v;
  endfunction

  // one instruction presented from now until it is captured
  task automatic op(input bit v, input bit mr, input bit mw, input bit rfw,
                    input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                    input logic [31:0] alu, input logic [31:0] sd,
                    input logic [31:0] rdata, input int waits);
    bit memop, flt, legal;
    int last;
    valid_in = v; mem_read = mr; mem_write = mw; reg_file_write_in = rfw;
    addr_rd_in = rd; select_mux_2_in = sel; funct3 = f3;
    alu_result = alu; store_data = sd; dmem_rdata = rdata;
    memop = v && (mr || mw);
    flt   = memop && m_fault(mr, f3, alu);
    legal = memop && !flt;
    last  = legal ? waits : 0;
    for (int c = 0; c <= last; c++) begin
      dmem_ready = legal && (c == waits);
      e_req   = legal;
      e_stall = legal && (c < waits);
      e_we    = mw && !mr;
      e_addr  = alu & 32'hFFFF_FFFC;
      e_be    = m_be(mr, f3, alu);
      e_wdata = mr ? sd : m_wdata(f3, sd);
      @(posedge clk); #1;
      if (legal && (c < waits)) e_fault = 0;
      else begin
        e_rfw   = v && rfw && !(mw && !mr) && !flt;
        e_rd    = rd;
        e_sel   = sel;
        e_alu   = alu;
        e_mem   = (v && mr && !flt) ? m_load(f3, alu, rdata) : 32'h0;
        e_fault = flt;
      end
    end
    dmem_ready = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall_out", stall_out, e_stall);
      chk("dmem_req", dmem_req, e_req);
      if (e_req) begin
        chk("dmem_we", dmem_we, e_we);
        chk("dmem_addr", dmem_addr, e_addr);
        chk("dmem_be", dmem_be, e_be);
        if (e_we) chk("dmem_wdata", dmem_wdata, e_wdata);
      end
      chk("rfw_out", reg_file_write_out, e_rfw);
      chk("addr_rd_out", addr_rd_out, e_rd);
      chk("sel_out", select_mux_2_out, e_sel);
      chk("alu_out", alu_out, e_alu);
      chk("mem_out", mem_out, e_mem);
      chk("fault_out", fault_out, e_fault);
    end
  end

  task automatic clear_exp();
    e_req = 0; e_stall = 0; e_we = 0; e_rfw = 0; e_fault = 0;
    e_addr = 0; e_wdata = 0; e_mem = 0; e_alu = 0; e_be = 0; e_rd = 0; e_sel = 0;
  endtask

  task automatic idle_inputs();
    valid_in = 0; mem_read = 0; mem_write = 0; reg_file_write_in = 0;
    alu_result = 0; store_data = 0; dmem_rdata = 0; funct3 = 0;
    addr_rd_in = 0; select_mux_2_in = 0; dmem_ready = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, dmem_req, 0);
    chk({tag, "_stall"}, stall_out, 0);
    chk({tag, "_we"}, dmem_we, 0);
    chk({tag, "_rfw"}, reg_file_write_out, 0);
    chk({tag, "_rd"}, addr_rd_out, 0);
    chk({tag, "_sel"}, select_mux_2_out, 0);
    chk({tag, "_mem"}, mem_out, 0);
    chk({tag, "_alu"}, alu_out, 0);
    chk({tag, "_fault"}, fault_out, 0);
  endtask

  initial begin
    clear_exp();
    #2 chk_all_zero("rst");
    @(posedge clk); @(posedge clk); #1;
    rst = 0; chk_en = 1;

    // model pins
    chk("pin_lb",   m_load(3'b000, 32'h1003, 32'h80AAAAAA), 32'hFFFFFF80);
    chk("pin_lbu",  m_load(3'b100, 32'h1003, 32'h80AAAAAA), 32'h00000080);
    chk("pin_sh_be", m_be(0, 3'b001, 32'h2002), 4'b1100);
    chk("pin_sh_wd", m_wdata(3'b001, 32'h0000BEEF), 32'hBEEFBEEF);
    chk("pin_lw_mis", m_fault(1, 3'b010, 32'h6), 1);

    // 1: ALU instruction
    op(1, 0, 0, 1, 5'd5, 2'b01, 3'b000, 32'h55555555, 0, 0, 0);
    chk("t1_alu", alu_out, 32'h55555555);
    chk("t1_rfw", reg_file_write_out, 1);
    // 2: LB / LBU with two wait states
    op(1, 1, 0, 1, 5'd7, 2'b00, 3'b000, 32'h1003, 0, 32'h80AAAAAA, 2);
    chk("t2_lb", mem_out, 32'hFFFFFF80);
    op(1, 1, 0, 1, 5'd7, 2'b00, 3'b100, 32'h1003, 0, 32'h80AAAAAA, 2);
    chk("t2_lbu", mem_out, 32'h00000080);
    // 3: SH zero-wait, then SB lane 1, SW, LH lane 2 with a wait state
    op(1, 0, 1, 1, 5'd3, 2'b00, 3'b001, 32'h2002, 32'h0000BEEF, 0, 0);
    chk("t3_sh_rfw", reg_file_write_out, 0);
    op(1, 0, 1, 1, 5'd3, 2'b00, 3'b000, 32'h3001, 32'h123456A5, 0, 1);
    op(1, 0, 1, 0, 5'd0, 2'b00, 3'b010, 32'h3004, 32'hCAFEF00D, 0, 0);
    op(1, 1, 0, 1, 5'd8, 2'b00, 3'b001, 32'h4002, 0, 32'h80015555, 1);
    chk("t3_lh", mem_out, 32'hFFFF8001);
    op(1, 1, 1, 1, 5'd9, 2'b00, 3'b010, 32'h4008, 0, 32'hDEADBEEF, 0);
    chk("t3_rw_as_load", mem_out, 32'hDEADBEEF);
    // 4: faults
    op(1, 1, 0, 1, 5'd9, 2'b00, 3'b010, 32'h6, 0, 0, 0);
    chk("t4_fault", fault_out, 1);
    chk("t4_rfw", reg_file_write_out, 0);
    op(1, 1, 0, 1, 5'd9, 2'b00, 3'b011, 32'h8, 0, 0, 0);
    chk("t4_f3_fault", fault_out, 1);
    op(1, 0, 1, 0, 5'd2, 2'b00, 3'b001, 32'h11, 32'h1, 0, 0);
    op(1, 0, 0, 1, 5'd6, 2'b01, 3'b000, 32'h1234, 0, 0, 0);
    chk("t4_pulse_end", fault_out, 0);

    // 5: reset while waiting
    chk_en = 0;
    valid_in = 1; mem_read = 1; mem_write = 0; reg_file_write_in = 1;
    funct3 = 3'b010; alu_result = 32'h40; addr_rd_in = 5'd12; dmem_ready = 0;
    @(posedge clk); #1;
    chk("t5_wait_req", dmem_req, 1);
    chk("t5_wait_stall", stall_out, 1);
    #2 rst = 1;
    #1 chk_all_zero("t5_rst");
    @(posedge clk); #1;
    idle_inputs(); rst = 0; clear_exp(); chk_en = 1;
    op(1, 0, 0, 1, 5'd13, 2'b01, 3'b000, 32'hA5A5_0001, 0, 0, 0);
    chk("t5_after", alu_out, 32'hA5A50001);

    // 6: bubble, then back-to-back LHU and ADD
    op(0, 0, 0, 1, 5'd4, 2'b01, 3'b000, 32'h99, 0, 0, 0);
    chk("t6_bubble", reg_file_write_out, 0);
    op(1, 1, 0, 1, 5'd10, 2'b00, 3'b101, 32'h10, 0, 32'h1234F00D, 0);
    chk("t6_lhu", mem_out, 32'h0000F00D);
    op(1, 0, 0, 1, 5'd11, 2'b01, 3'b000, 32'h77, 0, 0, 0);
    chk("t6_add_rd", addr_rd_out, 5'd11);
    chk("t6_add_alu", alu_out, 32'h77);

    idle_inputs();
    @(posedge clk); #1;
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline, directly upstream of the WB stage.
- Takes EX/MEM results, performs loads and stores on the data-memory port through a req/ready handshake, and aligns and sign-extends load data.
- Holds the MEM/WB pipeline register whose outputs feed the WB stage inputs directly: reg_file_write, addr_rd, select_mux_2, mem_out and alu_out.

Parameters:
- XLEN, 32, data and address width.

Ports:
- clk  in  1  stage clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valid_in  in  1  EX/MEM holds a valid instruction.
- alu_result  in  XLEN  effective address, or ALU result.
- store_data  in  XLEN  rs2 value for stores.
- funct3  in  3  access size and sign.
- mem_read  in  1  instruction is a load.
- mem_write  in  1  instruction is a store.
- reg_file_write_in  in  1  register-file write enable from decode.
- addr_rd_in  in  5  destination register.
- select_mux_2_in  in  2  WB mux select (00 memory, 01 ALU).
- stall_out  out  1  upstream must hold all inputs stable.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  XLEN  word-aligned address ({alu_result[31:2],2'b00}).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_ready  in  1  access complete; dmem_rdata valid this cycle.
- dmem_rdata  in  XLEN  read word.
- reg_file_write_out  out  1  to WB.
- addr_rd_out  out  5  to WB.
- select_mux_2_out  out  2  to WB.
- mem_out  out  XLEN  aligned and extended load data.
- alu_out  out  XLEN  registered alu_result.
- fault_out  out  1  one-cycle pulse: misaligned access or illegal funct3.

Behaviour:
- Memory operation (memop): valid_in & (mem_read | mem_write).
- Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: funct3 000 SB, 001 SH, 010 SW.
- Misaligned: halfword access with addr[0]=1, or word access with addr[1:0]≠00.
- A memop that is misaligned or uses an illegal funct3 is a fault.
- A fault issues no request and does not stall. Next edge: fault_out=1, reg_file_write_out=0, other WB fields captured normally.
- FSM states are IDLE and WAIT. Reset state is IDLE.
- In IDLE with a legal memop: dmem_req=1 combinationally.
  - If dmem_ready=1 in the same cycle, no stall; capture at the edge.
  - Otherwise stall_out=1 and the next state is WAIT.
- In WAIT: dmem_req=1 and stall_out=~dmem_ready. When dmem_ready=1, capture into MEM/WB and return to IDLE.
- dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata stay stable while a request is pending.
- mem_read=mem_write=1 together is treated as a load.
- Byte lane is addr[1:0].
  - SB: be=0001<<lane, wdata={4{sd[7:0]}}.
  - SH: be=0011<<lane, wdata={2{sd[15:0]}}.
  - SW: be=1111, wdata=sd.
  - Loads: be=1111.
- mem_out takes the lane byte or halfword of dmem_rdata. LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- For non-loads, mem_out=0.
- The MEM/WB register updates on every edge where stall_out=0.
  - If valid_in=0, the captured entry is a bubble: reg_file_write_out=0, other fields captured as-is.
  - Stores force reg_file_write_out=0.
  - Non-memory instructions pass through with 1-cycle latency.
  - A load with zero wait states has 1-cycle latency; N wait states give N+1 cycles.
- While stall_out=1, the MEM/WB outputs hold their values and fault_out=0.
- Reset values: all outputs 0 and FSM in IDLE. Reset during WAIT drops dmem_req asynchronously and abandons the access. Memory must tolerate the abandoned request.

Decomposition:
- Shared package riscv_pkg holds:
  - funct3 size codes: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - WB select codes: WB_SEL_MEM=2'b00, WB_SEL_ALU=2'b01.
  - State enum: MEM_IDLE, MEM_WAIT.
- Sub-module load_store_align (combinational) covers lane and be generation, store replication, load extraction and the fault decode.
- The FSM and MEM/WB register stay in mem_stage.

Test Plan:
1. ALU instruction (valid_in=1, mem_read=mem_write=0, alu_result=55555555, rd=5, reg_file_write_in=1, select_mux_2_in=01) -> next edge: alu_out=55555555, addr_rd_out=5, reg_file_write_out=1, select_mux_2_out=01, dmem_req=0 throughout.
2. LB at 0x1003, rdata=80AAAAAA, ready after 2 wait cycles -> be=1111, addr=1000, stall_out=1 for 2 cycles, then mem_out=FFFFFF80, reg_file_write_out=1. Same access as LBU -> mem_out=00000080.
3. SH at 0x2002, store_data=0000BEEF, ready same cycle -> dmem_we=1, be=1100, wdata=BEEFBEEF, no stall, reg_file_write_out=0.
4. LW at 0x0006 -> no dmem_req, fault_out=1 for one cycle, reg_file_write_out=0. funct3=011 load -> same response.
5. LW pending in WAIT, rst asserted -> dmem_req=0 immediately, all outputs 0, FSM in IDLE. After release, an ALU instruction passes normally.
6. valid_in=0 with reg_file_write_in=1 -> reg_file_write_out=0. Back-to-back LHU at 0x10 then ADD, both zero-wait -> consecutive cycles with correct WB fields and no bubble.
